dm_dump_unit: RTL and testbench

- 64-bit-word data memory placed directly downstream of processor_arm.
- Absorbs the processor's DM_writeData / DM_addr / DM_writeEnable stream and serves combinational reads back to the processor.
- On a rising edge of the top-level `dump` strobe, walks every word out through a valid/ready stream, giving the bench or UART a deterministic post-run memory image.

---
 rtl/dm_pkg.sv | 28 ++
 rtl/dm_dump_unit_if.sv | 27 ++
 rtl/dm_array.sv | 29 ++
 rtl/dm_dump_unit.sv | 119 +++++++++++
 tb/tb_dm_dump_unit.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared constants, FSM state type, dump beat payload and address helpers for the dump-capable data memory.
package dm_pkg;

  localparam int unsigned N     = 64;
  localparam int unsigned DEPTH = 64;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_t;

  typedef struct packed {
    logic [AW-1:0] index;
    logic [N-1:0]  data;
  } dump_beat_t;

  // Byte address to word index; the low three bits select a byte within the 8-byte word.
  function automatic logic [AW-1:0] word_index(input logic [N-1:0] addr);
    return addr[AW+2:3];
  endfunction

  function automatic logic in_range(input logic [N-1:0] addr);
    return (addr >> (AW + 3)) == '0;
  endfunction

endpackage

// File: rtl/dm_dump_unit_if.sv
// Processor-side memory bus plus the dump stream, bundled for the dump unit and its consumer.
interface dm_dump_if;
  import dm_pkg::*;

  logic          DM_writeEnable;
  logic [N-1:0]  DM_addr;
  logic [N-1:0]  DM_writeData;
  logic [N-1:0]  DM_readData;
  logic          dump;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_index;
  logic [N-1:0]  dump_data;
  logic          dump_done;
  logic          err_oob;

  modport slave (
    input  DM_writeEnable, DM_addr, DM_writeData, dump, dump_ready,
    output DM_readData, dump_valid, dump_index, dump_data, dump_done, err_oob
  );

  modport master (
    output DM_writeEnable, DM_addr, DM_writeData, dump, dump_ready,
    input  DM_readData, dump_valid, dump_index, dump_data, dump_done, err_oob
  );

endinterface

// File: rtl/dm_array.sv
// DEPTH x N word storage: one synchronous write port and two combinational read ports.
module dm_array
  import dm_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [N-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr_a,
  output logic [N-1:0]  o_rdata_a_c,
  input  logic [AW-1:0] i_raddr_b,
  output logic [N-1:0]  o_rdata_b_c
);

  logic [N-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem <= '{default: '0};
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a_c = r_mem[i_raddr_a];
  assign o_rdata_b_c = r_mem[i_raddr_b];

endmodule

// File: rtl/dm_dump_unit.sv
// Data memory for the single-cycle core with a rising-edge-triggered full-image dump over a valid/ready stream.
module dm_dump_unit
  import dm_pkg::*;
(
  input  logic     CLOCK_50,
  input  logic     reset,
  dm_dump_if.slave bus
);

  dump_state_t   r_state, w_state_nxt;
  logic [AW-1:0] r_ptr, w_ptr_nxt;
  dump_beat_t    r_beat, w_beat_nxt;
  logic          r_valid, w_valid_nxt;
  logic          r_done, w_done_nxt;
  logic          r_dump_q;
  logic          r_err_oob;

  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_we;
  logic [N-1:0]  w_rd_proc;
  logic [N-1:0]  w_rd_dump;
  logic [AW-1:0] w_ptr_inc;
  logic [AW-1:0] w_dump_raddr;
  logic          w_start;
  logic          w_hs;

  assign w_idx      = word_index(bus.DM_addr);
  assign w_in_range = in_range(bus.DM_addr);
  assign w_we       = bus.DM_writeEnable & w_in_range;
  assign w_ptr_inc  = r_ptr + AW'(1);
  assign w_start    = bus.dump & ~r_dump_q;
  assign w_hs       = r_valid & bus.dump_ready;

  // Dump port looks one word ahead while scanning so the next beat is ready on the handshake edge.
  assign w_dump_raddr = (r_state == SCAN) ? w_ptr_inc : '0;

  dm_array u_array (
    .clk         (CLOCK_50),
    .rst         (reset),
    .i_we        (w_we),
    .i_waddr     (w_idx),
    .i_wdata     (bus.DM_writeData),
    .i_raddr_a   (w_idx),
    .o_rdata_a_c (w_rd_proc),
    .i_raddr_b   (w_dump_raddr),
    .o_rdata_b_c (w_rd_dump)
  );

  assign bus.DM_readData = w_in_range ? w_rd_proc : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_beat_nxt  = r_beat;
    w_valid_nxt = r_valid;
    w_done_nxt  = r_done;
    unique case (r_state)
      IDLE: begin
        if (w_start) begin
          w_ptr_nxt        = '0;
          w_beat_nxt.index = '0;
          w_beat_nxt.data  = w_rd_dump;
          w_valid_nxt      = 1'b1;
          w_state_nxt      = SCAN;
        end
      end
      SCAN: begin
        if (w_hs) begin
          if (r_ptr == AW'(DEPTH - 1)) begin
            w_valid_nxt = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_ptr_nxt        = w_ptr_inc;
            w_beat_nxt.index = w_ptr_inc;
            w_beat_nxt.data  = w_rd_dump;
          end
        end
      end
      DONE: begin
        if (!bus.dump) begin
          w_done_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_beat    <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
      r_dump_q  <= 1'b0;
      r_err_oob <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_beat    <= w_beat_nxt;
      r_valid   <= w_valid_nxt;
      r_done    <= w_done_nxt;
      r_dump_q  <= bus.dump;
      r_err_oob <= r_err_oob | (bus.DM_writeEnable & ~w_in_range);
    end
  end

  assign bus.dump_valid = r_valid;
  assign bus.dump_index = r_beat.index;
  assign bus.dump_data  = r_beat.data;
  assign bus.dump_done  = r_done;
  assign bus.err_oob    = r_err_oob;

endmodule

// File: tb/tb_dm_dump_unit.sv
// Scoreboard bench for dm_dump_unit: directed writes/reads plus dump streams checked beat by beat.
module tb_dm_dump_unit;
  import dm_pkg::*;

  logic clk = 1'b0;
  logic reset;

  dm_dump_if bus();

  dm_dump_unit dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  dump_beat_t exp_q[$];
  logic [N-1:0] model [DEPTH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: each accepted beat must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset === 1'b0 && bus.dump_valid === 1'b1 && bus.dump_ready === 1'b1) begin
      dump_beat_t e;
      hs_cnt++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL dump_extra_beat: got index %0d with no expected beat", bus.dump_index);
      end else begin
        e = exp_q.pop_front();
        check("dump_index", 64'(bus.dump_index), 64'(e.index));
        check("dump_data", bus.dump_data, e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [N-1:0] addr, input logic [N-1:0] data);
    bus.DM_writeEnable = 1'b1;
    bus.DM_addr        = addr;
    bus.DM_writeData   = data;
    tick();
    bus.DM_writeEnable = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [N-1:0] addr, input logic [N-1:0] exp);
    bus.DM_addr = addr;
    #1;
    check(name, bus.DM_readData, exp);
  endtask

  task automatic push_image();
    for (int i = 0; i < int'(DEPTH); i++) begin
      dump_beat_t b;
      b.index = AW'(i);
      b.data  = model[i];
      exp_q.push_back(b);
    end
  endtask

  // Raise dump with ready held high and wait (bounded) for dump_done.
  task automatic run_full_dump(input string name);
    int cyc;
    cyc = 0;
    bus.dump       = 1'b1;
    bus.dump_ready = 1'b1;
    while (bus.dump_done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
    check({name, "_cycles_to_done"}, 64'(cyc), 64'(DEPTH + 1));
    check({name, "_valid_low_at_done"}, 64'(bus.dump_valid), 64'd0);
    tick();
    check({name, "_done_held"}, 64'(bus.dump_done), 64'd1);
    bus.dump = 1'b0;
    tick();
    check({name, "_done_cleared"}, 64'(bus.dump_done), 64'd0);
    check({name, "_queue_drained"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cyc;
    bit did4, did7, did10;

    reset              = 1'b1;
    bus.DM_writeEnable = 1'b0;
    bus.DM_addr        = '0;
    bus.DM_writeData   = '0;
    bus.dump           = 1'b0;
    bus.dump_ready     = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;
    tick();
    tick();

    check("rst_valid", 64'(bus.dump_valid), 64'd0);
    check("rst_done", 64'(bus.dump_done), 64'd0);
    check("rst_err_oob", 64'(bus.err_oob), 64'd0);
    check("rst_index", 64'(bus.dump_index), 64'd0);
    check("rst_data", bus.dump_data, 64'd0);
    reset = 1'b0;
    tick();
    read_check("rst_read0", 64'h0, 64'h0);

    // Basic write/read and byte-offset aliasing within a word
    write_word(64'h10, 64'hDEAD_BEEF_0000_0001);
    model[2] = 64'hDEAD_BEEF_0000_0001;
    read_check("rd_addr_10", 64'h10, 64'hDEAD_BEEF_0000_0001);
    read_check("rd_addr_17", 64'h17, 64'hDEAD_BEEF_0000_0001);
    read_check("rd_addr_18", 64'h18, 64'h0);
    read_check("rd_addr_08", 64'h08, 64'h0);

    // Out-of-range write: no aliasing into word 0, sticky error
    write_word(64'h200, 64'h1234_5678_9ABC_DEF0);
    check("oob_err_set", 64'(bus.err_oob), 64'd1);
    read_check("oob_read", 64'h200, 64'h0);
    read_check("oob_no_alias", 64'h0, 64'h0);
    tick();
    tick();
    check("oob_err_sticky", 64'(bus.err_oob), 64'd1);
    write_word(64'h1F8, 64'hFACE);
    model[63] = 64'hFACE;
    read_check("rd_top_word", 64'h1FF, 64'hFACE);
    check("oob_no_false_err", 64'(bus.err_oob), 64'd1);

    // Fill image i*3 and dump with ready held high
    for (int i = 0; i < int'(DEPTH); i++) begin
      write_word(64'(i * 8), 64'(i * 3));
      model[i] = 64'(i * 3);
    end
    read_check("rd_fill_63", 64'(63 * 8), 64'd189);
    hs_cnt = 0;
    push_image();
    run_full_dump("dump1");
    check("dump1_beats", 64'(hs_cnt), 64'(DEPTH));

    // Backpressure at 7 plus writes racing the scan
    for (int i = 0; i < int'(DEPTH); i++) begin
      dump_beat_t b;
      b.index = AW'(i);
      b.data  = (i == 40) ? 64'hAA : model[i];
      exp_q.push_back(b);
    end
    hs_cnt = 0;
    did4 = 1'b0;
    did7 = 1'b0;
    did10 = 1'b0;
    bus.dump       = 1'b1;
    bus.dump_ready = 1'b1;
    cyc = 0;
    while (bus.dump_done !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
      bus.DM_writeEnable = 1'b0;
      if (bus.dump_valid && bus.dump_index == AW'(4) && !did4) begin
        did4 = 1'b1;
        bus.DM_writeEnable = 1'b1;
        bus.DM_addr        = 64'(5 * 8);
        bus.DM_writeData   = 64'h55;
      end
      if (bus.dump_valid && bus.dump_index == AW'(7) && !did7) begin
        did7 = 1'b1;
        bus.dump_ready = 1'b0;
        repeat (5) begin
          tick();
          cyc++;
          check("bp_valid", 64'(bus.dump_valid), 64'd1);
          check("bp_index", 64'(bus.dump_index), 64'd7);
          check("bp_data", bus.dump_data, 64'd21);
        end
        bus.dump_ready = 1'b1;
      end
      if (bus.dump_valid && bus.dump_index == AW'(10) && !did10) begin
        did10 = 1'b1;
        bus.DM_writeEnable = 1'b1;
        bus.DM_addr        = 64'(40 * 8);
        bus.DM_writeData   = 64'hAA;
      end
    end
    check("dump2_done", 64'(bus.dump_done), 64'd1);
    check("dump2_beats", 64'(hs_cnt), 64'(DEPTH));
    bus.dump = 1'b0;
    tick();
    check("dump2_done_cleared", 64'(bus.dump_done), 64'd0);
    check("dump2_queue_drained", 64'(exp_q.size()), 64'd0);
    model[5]  = 64'h55;
    model[40] = 64'hAA;
    read_check("rd_after_scan_5", 64'(5 * 8), 64'h55);
    read_check("rd_after_scan_40", 64'(40 * 8), 64'hAA);

    // Reset in the middle of a dump
    for (int i = 0; i < 20; i++) begin
      dump_beat_t b;
      b.index = AW'(i);
      b.data  = model[i];
      exp_q.push_back(b);
    end
    hs_cnt = 0;
    bus.dump       = 1'b1;
    bus.dump_ready = 1'b1;
    cyc = 0;
    while (!(bus.dump_valid === 1'b1 && bus.dump_index == AW'(20)) && cyc < 100) begin
      tick();
      cyc++;
    end
    check("mid_reach_20", 64'(bus.dump_index), 64'd20);
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 64'(bus.dump_valid), 64'd0);
    check("mid_rst_done", 64'(bus.dump_done), 64'd0);
    check("mid_rst_err", 64'(bus.err_oob), 64'd0);
    check("mid_rst_beats", 64'(hs_cnt), 64'd20);
    check("mid_rst_queue", 64'(exp_q.size()), 64'd0);
    read_check("mid_rst_rd2", 64'h10, 64'h0);
    read_check("mid_rst_rd40", 64'(40 * 8), 64'h0);
    read_check("mid_rst_rd63", 64'(63 * 8), 64'h0);
    for (int i = 0; i < int'(DEPTH); i++) model[i] = '0;

    // dump held high across reset release starts a fresh dump of the cleared image
    push_image();
    hs_cnt = 0;
    reset = 1'b0;
    run_full_dump("dump3");
    check("dump3_beats", 64'(hs_cnt), 64'(DEPTH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
